// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, header, payload, optional parity, stop bit, MSB-first.
// Optional feature: define PARITY_EN to insert an even-parity bit after the payload.
module serial_frame_tx #(
  parameter int HDR_W = 8,
  parameter int PAY_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [HDR_W-1:0] tx_hdr,
  input  logic [PAY_W-1:0] tx_data,
  output logic             tx_ready,
  output logic             serOut,
  output logic             busy,
  output logic             Done
);

  localparam int FRM_W = HDR_W + PAY_W;
  localparam int MAX_W = (HDR_W > PAY_W) ? HDR_W : PAY_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_W - 1);

  // state | meaning
  // IDLE  | line high, ready for a frame
  // START | start bit (low) on the line
  // HDR   | header bit cnt on the line
  // PAY   | payload bit cnt on the line
  // PAR   | even-parity bit on the line (PARITY_EN only)
  // STOP  | stop bit (high) on the line, Done pulse
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    HDR   = 3'd2,
    PAY   = 3'd3,
`ifdef PARITY_EN
    PAR   = 3'd4,
`endif
    STOP  = 3'd5
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic [FRM_W-1:0] shReg, nextSh;
  logic             nextSer;
`ifdef PARITY_EN
  logic             parBit, nextPar;
`endif

  // serOut is registered from the next-state decode so the line value lines up with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shReg  <= '0;
      serOut <= 1'b1;
`ifdef PARITY_EN
      parBit <= 1'b0;
`endif
    end else begin
      state  <= nextState;
      cnt    <= nextCnt;
      shReg  <= nextSh;
      serOut <= nextSer;
`ifdef PARITY_EN
      parBit <= nextPar;
`endif
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextSh    = shReg;
    nextSer   = 1'b1;
`ifdef PARITY_EN
    nextPar   = parBit;
`endif
    case (state)
      IDLE: begin
        if (tx_valid) begin
          nextState = START;
          nextSh    = {tx_hdr, tx_data};
          nextSer   = 1'b0;
`ifdef PARITY_EN
          nextPar   = ^{tx_hdr, tx_data};
`endif
        end
      end
      START: begin
        nextState = HDR;
        nextCnt   = '0;
        nextSer   = shReg[FRM_W-1];
        nextSh    = shReg << 1;
      end
      HDR: begin
        nextSer = shReg[FRM_W-1];
        nextSh  = shReg << 1;
        if (cnt == HDR_LAST) begin
          nextState = PAY;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + CNT_W'(1);
        end
      end
      PAY: begin
        if (cnt == PAY_LAST) begin
          nextCnt = '0;
`ifdef PARITY_EN
          nextState = PAR;
          nextSer   = parBit;
`else
          nextState = STOP;
          nextSer   = 1'b1;
`endif
        end else begin
          nextCnt = cnt + CNT_W'(1);
          nextSer = shReg[FRM_W-1];
          nextSh  = shReg << 1;
        end
      end
`ifdef PARITY_EN
      PAR: begin
        nextState = STOP;
        nextSer   = 1'b1;
      end
`endif
      STOP: begin
        nextState = IDLE;
        nextSer   = 1'b1;
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
        nextSer   = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign Done     = (state == STOP);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed self-checking bench for serial_frame_tx (default 8-bit header, 7-bit payload).
// Honours PARITY_EN when the same define is passed to the bench.
module tb_serial_frame_tx;

`ifdef PARITY_EN
  localparam int FLEN = 18;
`else
  localparam int FLEN = 17;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_hdr;
  logic [6:0] tx_data;
  logic       tx_ready, serOut, busy, Done;

  int checks = 0;
  int errors = 0;

  serial_frame_tx #(.HDR_W(8), .PAY_W(7)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_hdr(tx_hdr), .tx_data(tx_data),
    .tx_ready(tx_ready), .serOut(serOut), .busy(busy), .Done(Done)
  );

  always #5 clk = ~clk;

  function automatic logic [FLEN-1:0] mkFrame(input logic [7:0] h, input logic [6:0] d);
`ifdef PARITY_EN
    return {1'b0, h, d, ^{h, d}, 1'b1};
`else
    return {1'b0, h, d, 1'b1};
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".serOut"}, serOut, 1'b1);
    chk({tag, ".ready"}, tx_ready, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".Done"}, Done, 1'b0);
  endtask

  // Sends one frame; called just after a rising edge. Optionally scrambles the inputs mid-frame.
  task automatic runFrame(input string tag, input logic [7:0] h, input logic [6:0] d,
                          input logic [FLEN-1:0] exp, input bit scramble);
    tx_hdr = h; tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      chk($sformatf("%s.bit%0d", tag, i), serOut, exp[FLEN-1-i]);
      chk($sformatf("%s.done%0d", tag, i), Done, (i == FLEN-1));
      chk($sformatf("%s.ready%0d", tag, i), tx_ready, 1'b0);
      chk($sformatf("%s.busy%0d", tag, i), busy, 1'b1);
      if (scramble) begin
        tx_hdr  = 8'($urandom);
        tx_data = 7'($urandom);
      end
    end
    @(negedge clk);
    chkIdle({tag, ".after"});
    @(posedge clk); #1;
  endtask

  logic [FLEN-1:0] refA5, f1, f2;

  initial begin
`ifdef PARITY_EN
    refA5 = 18'b0_10100101_0101100_1_1;
`else
    refA5 = 17'b0_10100101_0101100_1;
`endif
    rst = 1'b0; tx_valid = 1'b0; tx_hdr = '0; tx_data = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkIdle($sformatf("reset%0d", i));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chkIdle("postReset");
    @(posedge clk); #1;

    // single frame against the hand-written bit pattern
    runFrame("single", 8'hA5, 7'h2C, refA5, 1'b0);

    // inputs change every cycle mid-frame: line must keep the latched values
    runFrame("ignore", 8'h96, 7'h33, mkFrame(8'h96, 7'h33), 1'b1);

    // back-to-back with tx_valid held high
    f1 = refA5;
    f2 = mkFrame(8'h3C, 7'h7F);
    tx_hdr = 8'hA5; tx_data = 7'h2C; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_hdr = 8'h3C; tx_data = 7'h7F;
    for (int i = 0; i < 2*FLEN+1; i++) begin
      @(negedge clk);
      if (i < FLEN) begin
        chk($sformatf("b2b.f1bit%0d", i), serOut, f1[FLEN-1-i]);
        chk($sformatf("b2b.f1done%0d", i), Done, (i == FLEN-1));
      end else if (i == FLEN) begin
        chk("b2b.gapLine", serOut, 1'b1);
        chk("b2b.gapReady", tx_ready, 1'b1);
        chk("b2b.gapDone", Done, 1'b0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
      end else begin
        chk($sformatf("b2b.f2bit%0d", i-FLEN-1), serOut, f2[2*FLEN-i]);
        chk($sformatf("b2b.f2done%0d", i-FLEN-1), Done, (i == 2*FLEN));
      end
    end
    @(negedge clk);
    chkIdle("b2b.after");

    // abort during header bit 4 (line index 5 after the accept edge)
    @(posedge clk); #1;
    tx_hdr = 8'hF0; tx_data = 7'h55; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("abort.preBit", serOut, 1'b0);
    chk("abort.preBusy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("abort.line", serOut, 1'b1);
    chk("abort.busy", busy, 1'b0);
    chk("abort.Done", Done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < FLEN+2; i++) begin
      @(negedge clk);
      chk($sformatf("abort.idleLine%0d", i), serOut, 1'b1);
      chk($sformatf("abort.idleDone%0d", i), Done, 1'b0);
    end
    @(posedge clk); #1;
    runFrame("afterAbort", 8'h3C, 7'h7F, mkFrame(8'h3C, 7'h7F), 1'b0);

`ifdef PARITY_EN
    runFrame("parZero", 8'h00, 7'h00, 18'b0_00000000_0000000_0_1, 1'b0);
    runFrame("parOdd", 8'h01, 7'h00, 18'b0_00000001_0000000_1_1, 1'b0);
`else
    runFrame("zeros", 8'h00, 7'h00, 17'b0_00000000_0000000_1, 1'b0);
    runFrame("ones", 8'hFF, 7'h7F, 17'b0_11111111_1111111_1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
